sram_arbiter: RTL
=================

# sram_arbiter

Two-port arbiter sharing the single backing SRAM between the instruction cache (master 0) and the data cache (master 1) of the pipeline. Each master speaks the cache-side SRAM protocol. The master raises req with stable addr/wr_en/wdata and holds it across consecutive transactions; each transaction completes on a one-cycle ready. The arbiter grants round-robin and locks the grant while the owner's req stays high, so a write-back plus refill pair is never split. It also flags SRAM transactions that exceed a cycle budget.

## Interface
- TIMEOUT_CYC, 1024: cycles without ready, while granted and requesting, before o_err sets. 0 disables. Max 65535.
- i_clk  in  1  clock
- i_reset  in  1  reset, asynchronous, active-high
- i_m0_req / i_m1_req  in  1  master request, held until the master finishes
- i_m0_addr / i_m1_addr  in  32  transaction address
- i_m0_wr_en / i_m1_wr_en  in  1  1 = write, 0 = read
- i_m0_wdata / i_m1_wdata  in  32  write data
- o_m0_rdata / o_m1_rdata  out  32  read data, driven by i_sram_rdata to both masters
- o_m0_ready / o_m1_ready  out  1  transaction done, routed to the owner only
- o_sram_req  out  1  request to SRAM
- o_sram_addr  out  32  address to SRAM
- o_sram_wr_en  out  1  write enable to SRAM
- o_sram_wdata  out  32  write data to SRAM
- i_sram_rdata  in  32  read data from SRAM
- i_sram_ready  in  1  one-cycle completion pulse from SRAM
- o_grant  out  2  one-hot owner: bit0 = m0, bit1 = m1, 00 = none
- o_err  out  1  sticky timeout flag

## Operation
- States: IDLE, OWN0, OWN1, held in a registered state; o_grant decodes the state.
- last_owner register, reset to 1, so m0 wins the first tie.

**IDLE**
- Only m0 requesting → OWN0.
- Only m1 requesting → OWN1.
- Both requesting → OWN of the master that is not last_owner.
- Neither requesting → stay in IDLE.

**OWNx**
- The SRAM bus mirrors master x: o_sram_req = i_mx_req; addr, wr_en and wdata are x's.
- o_mx_ready = i_sram_ready & i_mx_req.
- The other master's ready is 0.
- Stay in OWNx while i_mx_req = 1, across any number of ready pulses.
- i_mx_req = 0 → release the grant and set last_owner = x.
  - If the other master is requesting, next state is OWN(other), with no IDLE cycle.
  - Otherwise next state is IDLE.

**Bus outside ownership**
- In IDLE: o_sram_req, addr, wr_en and wdata are all 0.

**Timeout**
- 16-bit counter increments each OWNx cycle with i_mx_req = 1 and i_sram_ready = 0.
- The counter clears on i_sram_ready, on release, and in IDLE.
- When the counter reaches TIMEOUT_CYC (and TIMEOUT_CYC ≠ 0), o_err sets and stays set until reset.
- A timeout does not release the grant.

**Masters' rdata**
- Both o_mx_rdata follow i_sram_rdata combinationally at all times.
- Each master qualifies rdata with its own ready.

## Timing
- Grant latency: a req first seen in IDLE gets o_grant and o_sram_req on the next clock edge, i.e. 1 cycle.
- The request-to-SRAM and ready-to-master paths are combinational through the mux and are not registered.
- Release gap: in the cycle where the owner's req is 0, o_sram_req = 0. The new owner drives the SRAM on the next cycle.
  - Ownership changes therefore always leave at least one idle bus cycle.
- A ready pulse in a cycle where the owner's req = 0 is ignored and not forwarded.
- A new request arriving while a master owns the bus waits. Maximum wait is the owner's full lock plus 1 cycle, and no starvation is possible because of the round-robin on release.
- Simultaneous owner release and other-master request: handoff occurs the same edge.
- Reset, asynchronous:
  - state = IDLE, last_owner = 1, counter = 0.
  - o_err = 0, o_grant = 00, o_sram_req = 0, both ready = 0.
  - Reset is legal mid-transaction; the masters are reset by the same i_reset.

## Test plan
- **Single m0 read:** m0 req at cycle 0 with addr 0x40, SRAM ready at cycle 3 with rdata 0xDEADBEEF.
  - o_grant = 01 at cycle 1.
  - o_m0_ready = 1 and o_m0_rdata = 0xDEADBEEF at cycle 3.
  - o_m1_ready = 0 throughout.
- **Tie after reset:** both req at cycle 0 → OWN0 at cycle 1. m0 drops req after its ready → o_sram_req = 0 for 1 cycle, then o_grant = 10.
- **Locked write-back plus refill:** m1 holds req across a write (wdata 0x12345678, wr_en = 1) then a read, with two ready pulses. m0 requests mid-way.
  - m0 is not granted until m1's req drops.
  - The SRAM sees wr_en = 1 then wr_en = 0, both with m1's addr.
- **Round-robin fairness:** both masters request continuously, each issuing one transaction per lock.
  - Grants alternate 01, 10, 01, 10.
  - Neither master waits more than one lock plus 1 cycle.
- **Timeout:** TIMEOUT_CYC = 8, m0 granted, no ready.
  - o_err rises when the counter reaches 8 and stays high after a later ready.
  - An async reset clears o_err and forces o_grant = 00 immediately.

Source files
------------

// File: rtl/sram_arbiter_if.sv
// Bundle of the two cache-side master ports, the SRAM-side port and the
// arbiter status outputs. The arbiter connects through the slave modport;
// the environment (masters + SRAM model) uses the master modport.
interface sram_arbiter_if;
  // master 0 (instruction cache)
  logic        i_m0_req;
  logic [31:0] i_m0_addr;
  logic        i_m0_wr_en;
  logic [31:0] i_m0_wdata;
  logic [31:0] o_m0_rdata;
  logic        o_m0_ready;
  // master 1 (data cache)
  logic        i_m1_req;
  logic [31:0] i_m1_addr;
  logic        i_m1_wr_en;
  logic [31:0] i_m1_wdata;
  logic [31:0] o_m1_rdata;
  logic        o_m1_ready;
  // shared SRAM
  logic        o_sram_req;
  logic [31:0] o_sram_addr;
  logic        o_sram_wr_en;
  logic [31:0] o_sram_wdata;
  logic [31:0] i_sram_rdata;
  logic        i_sram_ready;
  // status
  logic [1:0]  o_grant;
  logic        o_err;

  modport slave (
    input  i_m0_req, i_m0_addr, i_m0_wr_en, i_m0_wdata,
    input  i_m1_req, i_m1_addr, i_m1_wr_en, i_m1_wdata,
    input  i_sram_rdata, i_sram_ready,
    output o_m0_rdata, o_m0_ready, o_m1_rdata, o_m1_ready,
    output o_sram_req, o_sram_addr, o_sram_wr_en, o_sram_wdata,
    output o_grant, o_err
  );

  modport master (
    output i_m0_req, i_m0_addr, i_m0_wr_en, i_m0_wdata,
    output i_m1_req, i_m1_addr, i_m1_wr_en, i_m1_wdata,
    output i_sram_rdata, i_sram_ready,
    input  o_m0_rdata, o_m0_ready, o_m1_rdata, o_m1_ready,
    input  o_sram_req, o_sram_addr, o_sram_wr_en, o_sram_wdata,
    input  o_grant, o_err
  );
endinterface

// File: rtl/sram_arbiter.sv
// Round-robin, lock-while-requesting arbiter sharing one SRAM between the
// instruction cache (m0) and the data cache (m1). The owner keeps the bus for
// as long as it holds req, so multi-transaction sequences are never split.
// A sticky error flags an owner transaction stalled for TIMEOUT_CYC cycles.
module sram_arbiter #(
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input logic           i_clk,
  input logic           i_reset,
  sram_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    OWN0 = 2'b01,
    OWN1 = 2'b10
  } state_e;

  localparam logic [15:0] TIMEOUT_W  = 16'(TIMEOUT_CYC);
  localparam logic        TIMEOUT_EN = (TIMEOUT_CYC != 32'd0);

  state_e      state_q, state_d;
  logic        last_q, last_d;   // 1'b0 = m0 released last, 1'b1 = m1
  logic [15:0] cnt_q, cnt_d;
  logic        err_q, err_d;

  logic        sram_req_s;
  logic [31:0] sram_addr_s;
  logic        sram_wr_en_s;
  logic [31:0] sram_wdata_s;
  logic        m0_ready_s;
  logic        m1_ready_s;
  logic        stall_s;
  logic [1:0]  grant_s;

  // State, round-robin history, stall counter and sticky error registers.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      cnt_q   <= 16'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Next owner: round-robin from IDLE, hold while owner requests, hand off on release.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (bus.i_m0_req && bus.i_m1_req) begin
          state_d = last_q ? OWN0 : OWN1;
        end else if (bus.i_m0_req) begin
          state_d = OWN0;
        end else if (bus.i_m1_req) begin
          state_d = OWN1;
        end else begin
          state_d = IDLE;
        end
      end
      OWN0: begin
        if (!bus.i_m0_req) begin
          last_d  = 1'b0;
          state_d = bus.i_m1_req ? OWN1 : IDLE;
        end else begin
          state_d = OWN0;
        end
      end
      OWN1: begin
        if (!bus.i_m1_req) begin
          last_d  = 1'b1;
          state_d = bus.i_m0_req ? OWN0 : IDLE;
        end else begin
          state_d = OWN1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Combinational SRAM bus mux and ready routing to the current owner only.
  always_comb begin
    sram_req_s   = 1'b0;
    sram_addr_s  = 32'd0;
    sram_wr_en_s = 1'b0;
    sram_wdata_s = 32'd0;
    m0_ready_s   = 1'b0;
    m1_ready_s   = 1'b0;
    stall_s      = 1'b0;
    grant_s      = 2'b00;
    case (state_q)
      OWN0: begin
        sram_req_s   = bus.i_m0_req;
        sram_addr_s  = bus.i_m0_addr;
        sram_wr_en_s = bus.i_m0_wr_en;
        sram_wdata_s = bus.i_m0_wdata;
        m0_ready_s   = bus.i_sram_ready & bus.i_m0_req;
        stall_s      = bus.i_m0_req & ~bus.i_sram_ready;
        grant_s      = 2'b01;
      end
      OWN1: begin
        sram_req_s   = bus.i_m1_req;
        sram_addr_s  = bus.i_m1_addr;
        sram_wr_en_s = bus.i_m1_wr_en;
        sram_wdata_s = bus.i_m1_wdata;
        m1_ready_s   = bus.i_sram_ready & bus.i_m1_req;
        stall_s      = bus.i_m1_req & ~bus.i_sram_ready;
        grant_s      = 2'b10;
      end
      default: begin
        sram_req_s = 1'b0;
      end
    endcase
  end

  // Stall counter (saturating) and sticky timeout flag; a timeout keeps the grant.
  always_comb begin
    cnt_d = 16'd0;
    err_d = err_q;
    if (stall_s) begin
      cnt_d = (cnt_q == 16'hFFFF) ? cnt_q : (cnt_q + 16'd1);
    end else begin
      cnt_d = 16'd0;
    end
    if (TIMEOUT_EN && (cnt_d == TIMEOUT_W)) begin
      err_d = 1'b1;
    end else begin
      err_d = err_q;
    end
  end

  assign bus.o_sram_req   = sram_req_s;
  assign bus.o_sram_addr  = sram_addr_s;
  assign bus.o_sram_wr_en = sram_wr_en_s;
  assign bus.o_sram_wdata = sram_wdata_s;
  assign bus.o_m0_ready   = m0_ready_s;
  assign bus.o_m1_ready   = m1_ready_s;
  assign bus.o_m0_rdata   = bus.i_sram_rdata;
  assign bus.o_m1_rdata   = bus.i_sram_rdata;
  assign bus.o_grant      = grant_s;
  assign bus.o_err        = err_q;

endmodule
